// File: rtl/axi_gen_cmd_arb_if.sv
// Command/response bundle between the traffic-generator queues, the arbiter
// and the bus0 master driver.
interface axi_gen_cmd_arb_if #(
    parameter int N  = 5,
    parameter int AW = 32
);
    localparam int SW = $clog2(N);

    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;

    logic            m_vld;
    logic            m_rdy;
    logic            m_wr;
    logic [AW-1:0]   m_addr;
    logic [7:0]      m_len;
    logic [SW-1:0]   m_id;

    logic            rsp_vld;
    logic            rsp_last;
    logic [SW-1:0]   rsp_id;
    logic [N-1:0]    rsp_done;

    logic            ost_busy;
    logic            err;

    modport master (
        input  req_vld, req_wr, req_addr, req_len, m_rdy, rsp_vld, rsp_last, rsp_id,
        output req_rdy, m_vld, m_wr, m_addr, m_len, m_id, rsp_done, ost_busy, err
    );

    modport slave (
        output req_vld, req_wr, req_addr, req_len, m_rdy, rsp_vld, rsp_last, rsp_id,
        input  req_rdy, m_vld, m_wr, m_addr, m_len, m_id, rsp_done, ost_busy, err
    );
endinterface

// File: rtl/axi_gen_cmd_arb.sv
// Round-robin arbiter sharing one bus0 command port among N generators, with
// per-source outstanding limits. Define ARB_GRANT_CNT_EN for per-source grant counters.
module axi_gen_cmd_arb #(
    parameter int N       = 5,
    parameter int AW      = 32,
    parameter int OST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_gen_cmd_arb_if.master bus
`ifdef ARB_GRANT_CNT_EN
    ,
    input  logic              grant_clr,
    output logic [N*16-1:0]   grant_cnt
`endif
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(OST_MAX + 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        rr_q, rr_d;
    logic [SW-1:0]        m_id_q, m_id_d;
    logic                 m_wr_q, m_wr_d;
    logic [AW-1:0]        m_addr_q, m_addr_d;
    logic [7:0]           m_len_q, m_len_d;
    logic [N-1:0][CW-1:0] ost_cnt_q, ost_cnt_d;
    logic                 err_q, err_d;
    logic                 ost_busy_q, ost_busy_d;

    logic [N-1:0]         elig;
    logic [N-1:0]         req_rdy;
    logic [N-1:0]         rsp_done;
    logic [SW-1:0]        gnt_idx;
    logic [SW-1:0]        cand;
    logic                 gnt_found;
    logic                 accept;
    logic                 rsp_end;

    assign accept  = (state_q == ISSUE) && bus.m_rdy;
    assign rsp_end = bus.rsp_vld && bus.rsp_last;

    // An out-of-range rsp_id matches no index, so it never produces a done pulse.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i]     = bus.req_vld[i] && (ost_cnt_q[i] < CW'(OST_MAX));
            rsp_done[i] = rsp_end && (bus.rsp_id == SW'(i)) && (ost_cnt_q[i] != '0);
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SW'((int'(rr_q) + k) % N);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        m_id_d   = m_id_q;
        m_wr_d   = m_wr_q;
        m_addr_d = m_addr_q;
        m_len_d  = m_len_q;
        req_rdy  = '0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_rdy[gnt_idx] = 1'b1;
                    m_id_d   = gnt_idx;
                    m_wr_d   = bus.req_wr[gnt_idx];
                    m_addr_d = bus.req_addr[int'(gnt_idx)*AW +: AW];
                    m_len_d  = bus.req_len[int'(gnt_idx)*8 +: 8];
                    rr_d     = gnt_idx;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue and completion on the same source in one cycle cancel out.
    always_comb begin
        ost_busy_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            ost_cnt_d[i] = ost_cnt_q[i];
            if (accept && (m_id_q == SW'(i))) ost_cnt_d[i] = ost_cnt_d[i] + CW'(1);
            if (rsp_done[i])                  ost_cnt_d[i] = ost_cnt_d[i] - CW'(1);
            ost_busy_d = ost_busy_d | (ost_cnt_d[i] != '0);
        end
        err_d = err_q | (rsp_end && (rsp_done == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= SW'(N - 1);
            m_id_q     <= '0;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_len_q    <= '0;
            ost_cnt_q  <= '0;
            err_q      <= 1'b0;
            ost_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            m_id_q     <= m_id_d;
            m_wr_q     <= m_wr_d;
            m_addr_q   <= m_addr_d;
            m_len_q    <= m_len_d;
            ost_cnt_q  <= ost_cnt_d;
            err_q      <= err_d;
            ost_busy_q <= ost_busy_d;
        end
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.rsp_done = rsp_done;
    assign bus.m_vld    = (state_q == ISSUE);
    assign bus.m_wr     = m_wr_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_len    = m_len_q;
    assign bus.m_id     = m_id_q;
    assign bus.ost_busy = ost_busy_q;
    assign bus.err      = err_q;

`ifdef ARB_GRANT_CNT_EN
    logic [N-1:0][15:0] gcnt_q, gcnt_d;

    // Clear wins over a coincident accept.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (grant_clr)
                gcnt_d[i] = '0;
            else if (accept && (m_id_q == SW'(i)) && (gcnt_q[i] != 16'hFFFF))
                gcnt_d[i] = gcnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gcnt_q <= '0;
        else        gcnt_q <= gcnt_d;
    end

    assign grant_cnt = gcnt_q;
`endif
endmodule

// File: doc/axi_gen_cmd_arb.md
Name: axi_gen_cmd_arb

Overview:
- Shares one AXI master command port on bus0 between N traffic-generator sources (M_ID 0..N-1).
- Round-robin arbitration with per-source outstanding-transaction limits.
- Tags every issued command with the source index as the AXI ID and routes completion responses back to the owning source.
- Sits between the per-generator command queues and the bus0 master interface driver.

Parameters:
- N, 5, number of requesting sources (2..16).
- AW, 32, address width.
- OST_MAX, 4, maximum outstanding transactions per source (1..15).
- SW, $clog2(N), source-index / ID width (derived, not overridden).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  N  source i has a command pending
- req_rdy  out  N  one-cycle accept pulse to source i
- req_wr  in  N  1=write, 0=read, per source
- req_addr  in  N*AW  start address, source i at bits [i*AW +: AW]
- req_len  in  N*8  AXI burst length-1, source i at bits [i*8 +: 8]
- m_vld  out  1  command valid to bus master
- m_rdy  in  1  bus master accepts command
- m_wr  out  1  command direction
- m_addr  out  AW  command address
- m_len  out  8  command length
- m_id  out  SW  command ID = source index
- rsp_vld  in  1  response beat valid (B, or R beat)
- rsp_last  in  1  last beat of response (tie 1 for B)
- rsp_id  in  SW  response ID
- rsp_done  out  N  one-cycle completion pulse to source rsp_id
- ost_busy  out  1  any source has outstanding count > 0
- err  out  1  sticky: response for ID with zero outstanding, or rsp_id >= N

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr pointer=N-1; outstanding counters=0; err=0.
- Eligible(i) = req_vld[i] && ost_cnt[i] < OST_MAX.
- IDLE:
  - If any source is eligible, pick the first eligible index after the rr pointer, wrapping at N.
  - Register wr/addr/len/id into the m_* outputs; pulse req_rdy[i] in the same cycle.
  - Set rr pointer = i; go to ISSUE.
- ISSUE:
  - m_vld=1; m_* held stable until m_rdy.
  - On m_vld && m_rdy: ost_cnt[m_id]++, m_vld drops next cycle, go to IDLE.
- Throughput: one command per 2 cycles minimum.
- Latency: req_vld high → m_vld high at the next clock edge.
- No eligible source: stay in IDLE; m_vld=0; req_rdy=0.
- Completion: on rsp_vld && rsp_last with ost_cnt[rsp_id] > 0, decrement the counter and pulse rsp_done[rsp_id] in the same cycle (combinational from rsp inputs).
  - Non-last beats are ignored.
- Same-cycle issue and completion on the same source: counter unchanged; both the increment and the done pulse take effect.
- Completion with ost_cnt==0 or rsp_id >= N: no decrement, no rsp_done, err set until reset.
- Source at OST_MAX is skipped.
  - If it is the only requester, nothing issues until a completion arrives.
  - The counter never exceeds OST_MAX.
- Sources must hold req_* stable while req_vld=1 until req_rdy. Dropping req_vld before grant is legal; the source is simply not chosen.
- ost_busy = OR of (ost_cnt[i] != 0), registered.
- Async reset mid-ISSUE: m_vld drops immediately; in-flight command and counters are discarded.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt (N*16): per-source saturating count of accepted commands (m_vld && m_rdy), reset 0.
  - Adds input grant_clr (1): synchronous clear of all counts. If grant_clr coincides with an accept, the result is 0.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- N=5; only source 2 requests addr 0x1000, len 3, wr=1 → m_vld next cycle with m_addr=0x1000, m_len=3, m_wr=1, m_id=2; req_rdy[2] pulses once.
- All 5 sources hold req_vld, m_rdy=1, fast responses → issue order 0,1,2,3,4,0,1…; every source granted exactly 2 of the first 10 commands.
- Source 1 alone, no responses, OST_MAX=4 → exactly 4 issues, then m_vld stays 0. One rsp_vld/rsp_last with rsp_id=1 → rsp_done[1] pulses and a 5th command issues.
- m_rdy held 0 for 6 cycles in ISSUE → m_* stable; no other req_rdy pulses; rr pointer unchanged.
- Same-cycle accept on id 3 and last-beat response on id 3, starting count 2 → count remains 2; rsp_done[3] pulses.
- rsp_vld/rsp_last with rsp_id=4 while ost_cnt[4]=0 → err=1 and stays set; no rsp_done. With ARB_GRANT_CNT_EN, grant_cnt for sources 0..4 matches the issue counts and grant_clr zeros them.
